fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: multicycle instruction fetch / PC sequencer (FETCH -> EXEC -> [MEM] -> FETCH, sticky HALTED)
// Ports:
//   CLK, RST                 clock, async active-high reset
//   ihit, imemload           instruction read done / data; iREN, iaddr request / fetch address (PC)
//   dhit                     data access done; cu_dREN, cu_dWEN decoded data request
//   dmemREN, dmemWEN         data memory request (write wins when both latched)
//   PCSrc, imm16, addr,      next-PC select (NXT/BR/JMP/JR) and its operands
//   jr_addr
//   cu_halt                  decoded halt
//   instruction, instr_valid registered instruction and its valid flag
//   npc, halted              PC+4 link value, sticky halt flag
module fetch_unit #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        dhit,
    input  logic        cu_dREN,
    input  logic        cu_dWEN,
    output logic        dmemREN,
    output logic        dmemWEN,
    input  logic [1:0]  PCSrc,
    input  logic [15:0] imm16,
    input  logic [25:0] addr,
    input  logic [31:0] jr_addr,
    input  logic        cu_halt,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] npc,
    output logic        halted
);
    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALTED} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, next_pc, br_off;
    logic        rd_q, rd_d, wr_q, wr_d;
    assign npc     = pc_q + 32'd4;
    assign br_off  = {{14{imm16[15]}}, imm16, 2'b00};
    assign next_pc = (PCSrc == 2'd0) ? npc :
                     (PCSrc == 2'd1) ? npc + br_off :
                     (PCSrc == 2'd2) ? {npc[31:28], addr, 2'b00} : jr_addr;
    assign iREN        = (state_q == FETCH);
    assign iaddr       = pc_q;
    assign instr_valid = (state_q == EXEC) || (state_q == MEM);
    assign dmemWEN     = (state_q == MEM) && wr_q;
    assign dmemREN     = (state_q == MEM) && rd_q && !wr_q;
    assign halted      = (state_q == HALTED);
    assign instruction = instr_q;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        unique case (state_q)
            FETCH: if (ihit) begin
                instr_d = imemload;
                state_d = EXEC;
            end
            EXEC: if (cu_halt) begin
                state_d = HALTED;
            end else if (cu_dREN || cu_dWEN) begin
                rd_d    = cu_dREN;
                wr_d    = cu_dWEN;
                state_d = MEM;
            end else begin
                pc_d    = next_pc;
                state_d = FETCH;
            end
            // PC-update inputs must still be held by the control unit while the access completes
            MEM: if (dhit) begin
                pc_d    = next_pc;
                state_d = FETCH;
            end
            HALTED: state_d = HALTED;
        endcase
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= FETCH;
            pc_q    <= PC_INIT;
            instr_q <= 32'h0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
    logic        CLK = 1'b0, RST = 1'b1;
    logic        ihit = 1'b0, dhit = 1'b0, cu_dREN = 1'b0, cu_dWEN = 1'b0, cu_halt = 1'b0;
    logic [31:0] imemload = 32'h0, jr_addr = 32'h0;
    logic [1:0]  PCSrc = 2'd0;
    logic [15:0] imm16 = 16'h0;
    logic [25:0] addr = 26'h0;
    logic        iREN, dmemREN, dmemWEN, instr_valid, halted;
    logic [31:0] iaddr, instruction, npc;
    int tests = 0, fails = 0;

    fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .dhit(dhit), .cu_dREN(cu_dREN), .cu_dWEN(cu_dWEN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .PCSrc(PCSrc), .imm16(imm16), .addr(addr), .jr_addr(jr_addr), .cu_halt(cu_halt),
        .instruction(instruction), .instr_valid(instr_valid), .npc(npc), .halted(halted)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // one non-memory instruction: FETCH (ihit) -> EXEC -> FETCH with given next-PC select
    task automatic run_instr(input logic [1:0] src, input logic [15:0] imm, input logic [25:0] a, input logic [31:0] jr);
        PCSrc = src; imm16 = imm; addr = a; jr_addr = jr; ihit = 1'b1;
        tick();
        ihit = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #12;
        tests++; if (iREN !== 1'b1) begin fails++; $display("FAIL rst_iREN got %b exp 1", iREN); end
        tests++; if (iaddr !== 32'h0) begin fails++; $display("FAIL rst_iaddr got %h exp 00000000", iaddr); end
        tests++; if (npc !== 32'h4) begin fails++; $display("FAIL rst_npc got %h exp 00000004", npc); end
        tests++; if ({dmemREN, dmemWEN, instr_valid, halted} !== 4'b0) begin fails++; $display("FAIL rst_flags got %b exp 0000", {dmemREN, dmemWEN, instr_valid, halted}); end
        tests++; if (instruction !== 32'h0) begin fails++; $display("FAIL rst_instr got %h exp 00000000", instruction); end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_sequential();
        tick();
        tests++; if (iREN !== 1'b1 || iaddr !== 32'h0) begin fails++; $display("FAIL seq_wait got iREN=%b iaddr=%h exp 1 00000000", iREN, iaddr); end
        imemload = 32'h2021_0001; PCSrc = 2'd0; ihit = 1'b1;
        tick();
        ihit = 1'b0; imemload = 32'hDEAD_BEEF;
        tests++; if (instr_valid !== 1'b1 || iREN !== 1'b0) begin fails++; $display("FAIL seq_exec got valid=%b iREN=%b exp 1 0", instr_valid, iREN); end
        tests++; if (instruction !== 32'h2021_0001) begin fails++; $display("FAIL seq_instr got %h exp 20210001", instruction); end
        tick();
        tests++; if (iaddr !== 32'h4 || iREN !== 1'b1 || instr_valid !== 1'b0) begin fails++; $display("FAIL seq_next got iaddr=%h iREN=%b valid=%b exp 00000004 1 0", iaddr, iREN, instr_valid); end
        tests++; if (instruction !== 32'h2021_0001) begin fails++; $display("FAIL seq_instr_hold got %h exp 20210001", instruction); end
    endtask

    task automatic test_branch();
        run_instr(2'd0, 16'h0, 26'h0, 32'h0);
        run_instr(2'd0, 16'h0, 26'h0, 32'h0);
        run_instr(2'd0, 16'h0, 26'h0, 32'h0);
        tests++; if (iaddr !== 32'h10) begin fails++; $display("FAIL br_setup got %h exp 00000010", iaddr); end
        run_instr(2'd1, 16'hFFFE, 26'h0, 32'h0);
        tests++; if (iaddr !== 32'h0C) begin fails++; $display("FAIL br_neg got %h exp 0000000c", iaddr); end
        run_instr(2'd0, 16'h0, 26'h0, 32'h0);
        run_instr(2'd1, 16'h0003, 26'h0, 32'h0);
        tests++; if (iaddr !== 32'h20) begin fails++; $display("FAIL br_pos got %h exp 00000020", iaddr); end
    endtask

    task automatic test_jump();
        run_instr(2'd3, 16'h0, 26'h0, 32'hF000_0010);
        tests++; if (iaddr !== 32'hF000_0010) begin fails++; $display("FAIL jr_setup got %h exp f0000010", iaddr); end
        run_instr(2'd2, 16'h0, 26'h000_0040, 32'h0);
        tests++; if (iaddr !== 32'hF000_0100) begin fails++; $display("FAIL jmp got %h exp f0000100", iaddr); end
        run_instr(2'd3, 16'h0, 26'h0, 32'h0000_1234);
        tests++; if (iaddr !== 32'h0000_1234) begin fails++; $display("FAIL jr got %h exp 00001234", iaddr); end
    endtask

    task automatic test_load_stall();
        PCSrc = 2'd0; ihit = 1'b1;
        tick();
        ihit = 1'b0; cu_dREN = 1'b1;
        tick();
        cu_dREN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ihit = 1'b1;
            tests++; if (dmemREN !== 1'b1 || dmemWEN !== 1'b0 || iREN !== 1'b0 || instr_valid !== 1'b1 || iaddr !== 32'h1234) begin
                fails++; $display("FAIL ld_stall%0d got REN=%b WEN=%b iREN=%b valid=%b iaddr=%h exp 1 0 0 1 00001234", i, dmemREN, dmemWEN, iREN, instr_valid, iaddr);
            end
            tick();
        end
        ihit = 1'b0; dhit = 1'b1;
        tick();
        tests++; if (iaddr !== 32'h1238 || iREN !== 1'b1 || dmemREN !== 1'b0) begin fails++; $display("FAIL ld_done got iaddr=%h iREN=%b REN=%b exp 00001238 1 0", iaddr, iREN, dmemREN); end
        tick();
        dhit = 1'b0;
        tests++; if (iaddr !== 32'h1238 || iREN !== 1'b1 || instr_valid !== 1'b0) begin fails++; $display("FAIL dhit_in_fetch got iaddr=%h iREN=%b valid=%b exp 00001238 1 0", iaddr, iREN, instr_valid); end
        ihit = 1'b1;
        tick();
        ihit = 1'b0; cu_dREN = 1'b1; cu_dWEN = 1'b1;
        tick();
        cu_dREN = 1'b0; cu_dWEN = 1'b0;
        tests++; if (dmemWEN !== 1'b1 || dmemREN !== 1'b0) begin fails++; $display("FAIL st_priority got WEN=%b REN=%b exp 1 0", dmemWEN, dmemREN); end
        dhit = 1'b1;
        tick();
        dhit = 1'b0;
        tests++; if (iaddr !== 32'h123C || dmemWEN !== 1'b0) begin fails++; $display("FAIL st_done got iaddr=%h WEN=%b exp 0000123c 0", iaddr, dmemWEN); end
    endtask

    task automatic test_halt();
        ihit = 1'b1;
        tick();
        ihit = 1'b0; cu_halt = 1'b1; PCSrc = 2'd3; jr_addr = 32'h5555_0000;
        tick();
        cu_halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests++; if (halted !== 1'b1 || iREN !== 1'b0 || instr_valid !== 1'b0 || dmemREN !== 1'b0 || iaddr !== 32'h123C) begin
                fails++; $display("FAIL halt%0d got halted=%b iREN=%b valid=%b REN=%b iaddr=%h exp 1 0 0 0 0000123c", i, halted, iREN, instr_valid, dmemREN, iaddr);
            end
            ihit = 1'b1; dhit = 1'b1; cu_dREN = 1'b1;
            tick();
            ihit = 1'b0; dhit = 1'b0; cu_dREN = 1'b0;
        end
        #2 RST = 1'b1;
        #1;
        tests++; if (halted !== 1'b0 || iREN !== 1'b1 || iaddr !== 32'h0) begin fails++; $display("FAIL halt_rst got halted=%b iREN=%b iaddr=%h exp 0 1 00000000", halted, iREN, iaddr); end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_async_reset_mem();
        run_instr(2'd0, 16'h0, 26'h0, 32'h0);
        PCSrc = 2'd0; ihit = 1'b1;
        tick();
        ihit = 1'b0; cu_dREN = 1'b1;
        tick();
        cu_dREN = 1'b0;
        tests++; if (dmemREN !== 1'b1 || iaddr !== 32'h4) begin fails++; $display("FAIL mem_setup got REN=%b iaddr=%h exp 1 00000004", dmemREN, iaddr); end
        #2 RST = 1'b1;
        #1;
        tests++; if (dmemREN !== 1'b0 || iREN !== 1'b1 || iaddr !== 32'h0) begin fails++; $display("FAIL mem_async_rst got REN=%b iREN=%b iaddr=%h exp 0 1 00000000", dmemREN, iREN, iaddr); end
        RST = 1'b0;
        dhit = 1'b1;
        tick();
        dhit = 1'b0;
        tests++; if (iaddr !== 32'h0 || iREN !== 1'b1) begin fails++; $display("FAIL mem_rst_release got iaddr=%h iREN=%b exp 00000000 1", iaddr, iREN); end
    endtask

    task automatic test_wrap();
        run_instr(2'd3, 16'h0, 26'h0, 32'hFFFF_FFFC);
        tests++; if (iaddr !== 32'hFFFF_FFFC || npc !== 32'h0) begin fails++; $display("FAIL wrap_setup got iaddr=%h npc=%h exp fffffffc 00000000", iaddr, npc); end
        run_instr(2'd0, 16'h0, 26'h0, 32'h0);
        tests++; if (iaddr !== 32'h0) begin fails++; $display("FAIL wrap got %h exp 00000000", iaddr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_load_stall();
        test_halt();
        test_async_reset_mem();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
